// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache with one outstanding request.
//
// Request side : req_addr_i/req_valid_i/req_ready_o (word address).
// Response side: resp_addr_o/resp_data_o/resp_valid_o/resp_ready_i, held until accepted.
// Memory side  : mem_req_addr_o/mem_req_valid_o/mem_req_ready_i for the fill request,
//                mem_resp_data_i/mem_resp_valid_i/mem_resp_ready_o for the fill data.
// flush_i      : one-cycle pulse from fetch that discards any pending/in-flight response.
// clk_i/rst_i  : single rising-edge clock, synchronous active-high reset.
//
// Build option: define ICACHE_FLUSH_INVALIDATE_EN to make flush_i also clear every valid bit
// and keep a dropped fill from being installed valid. Undefined, flush never touches the array.

package icache_pkg;
  typedef logic [31:0] memaddr_t;
  typedef logic [31:0] word_t;
endpackage

module icache
  import icache_pkg::*;
#(
  parameter int unsigned LINES = 64
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     flush_i,
  input  memaddr_t req_addr_i,
  input  logic     req_valid_i,
  output logic     req_ready_o,
  output memaddr_t resp_addr_o,
  output word_t    resp_data_o,
  output logic     resp_valid_o,
  input  logic     resp_ready_i,
  output memaddr_t mem_req_addr_o,
  output logic     mem_req_valid_o,
  input  logic     mem_req_ready_i,
  input  word_t    mem_resp_data_i,
  input  logic     mem_resp_valid_i,
  output logic     mem_resp_ready_o
);

  localparam int unsigned AddrW = $bits(memaddr_t);
  localparam int unsigned IdxW  = $clog2(LINES);
  localparam int unsigned TagW  = AddrW - IdxW;

  typedef enum logic [2:0] {
    StIdle,
    StLookup,
    StFillReq,
    StFillWait,
    StResp
  } state_e;

  state_e state_q, state_d;

  memaddr_t addr_q;
  logic     drop_q, drop_d;

  logic [LINES-1:0] valid_q, valid_d;
  logic [TagW-1:0]  tag_mem  [LINES];
  word_t            data_mem [LINES];
  logic [TagW-1:0]  rd_tag_q;
  word_t            rd_data_q;

  logic     resp_valid_q, resp_valid_d;
  memaddr_t resp_addr_q, resp_addr_d;
  word_t    resp_data_q, resp_data_d;
  logic     mem_req_valid_q, mem_req_valid_d;
  memaddr_t mem_req_addr_q, mem_req_addr_d;

  logic [IdxW-1:0] req_idx, addr_idx;
  logic [TagW-1:0] addr_tag;
  logic            accept, hit, dropping, fill_we, fill_set_valid;

  assign req_idx  = req_addr_i[IdxW-1:0];
  assign addr_idx = addr_q[IdxW-1:0];
  assign addr_tag = addr_q[AddrW-1:IdxW];

  assign req_ready_o      = (state_q == StIdle) ||
                            ((state_q == StResp) && (resp_ready_i || flush_i));
  assign accept           = req_valid_i && req_ready_o;
  assign mem_resp_ready_o = (state_q == StFillWait);

  // Tag/data come from the registered array read launched at accept; the valid bit is read
  // live so an invalidating flush on the accept edge is already visible in LOOKUP.
  assign hit      = valid_q[addr_idx] && (rd_tag_q == addr_tag);
  // A flush arriving together with the fill data still discards that response.
  assign dropping = drop_q || flush_i;

  assign resp_valid_o    = resp_valid_q;
  assign resp_addr_o     = resp_addr_q;
  assign resp_data_o     = resp_data_q;
  assign mem_req_valid_o = mem_req_valid_q;
  assign mem_req_addr_o  = mem_req_addr_q;

  always_comb begin
    state_d         = state_q;
    drop_d          = drop_q;
    resp_valid_d    = resp_valid_q;
    resp_addr_d     = resp_addr_q;
    resp_data_d     = resp_data_q;
    mem_req_valid_d = mem_req_valid_q;
    mem_req_addr_d  = mem_req_addr_q;
    fill_we         = 1'b0;
    fill_set_valid  = 1'b0;

    case (state_q)
      StIdle: begin
        if (accept) state_d = StLookup;
      end
      StLookup: begin
        if (flush_i) begin
          state_d = StIdle;
        end else if (hit) begin
          resp_valid_d = 1'b1;
          resp_addr_d  = addr_q;
          resp_data_d  = rd_data_q;
          state_d      = StResp;
        end else begin
          mem_req_valid_d = 1'b1;
          mem_req_addr_d  = addr_q;
          state_d         = StFillReq;
        end
      end
      StFillReq: begin
        if (flush_i) drop_d = 1'b1;
        if (mem_req_ready_i) begin
          mem_req_valid_d = 1'b0;
          state_d         = StFillWait;
        end
      end
      StFillWait: begin
        if (flush_i) drop_d = 1'b1;
        if (mem_resp_valid_i) begin
          fill_we = 1'b1;
          drop_d  = 1'b0;
`ifdef ICACHE_FLUSH_INVALIDATE_EN
          fill_set_valid = !dropping;
`else
          fill_set_valid = 1'b1;
`endif
          if (dropping) begin
            state_d = StIdle;
          end else begin
            resp_valid_d = 1'b1;
            resp_addr_d  = addr_q;
            resp_data_d  = mem_resp_data_i;
            state_d      = StResp;
          end
        end
      end
      StResp: begin
        // A flush here retires the response; a coincident handshake still counts as delivered.
        if (resp_ready_i || flush_i) begin
          resp_valid_d = 1'b0;
          state_d      = accept ? StLookup : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
`ifdef ICACHE_FLUSH_INVALIDATE_EN
    if (flush_i) valid_d = '0;
`endif
    if (fill_we && fill_set_valid) valid_d[addr_idx] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= StIdle;
      addr_q          <= '0;
      drop_q          <= 1'b0;
      valid_q         <= '0;
      resp_valid_q    <= 1'b0;
      resp_addr_q     <= '0;
      resp_data_q     <= '0;
      mem_req_valid_q <= 1'b0;
      mem_req_addr_q  <= '0;
    end else begin
      state_q         <= state_d;
      drop_q          <= drop_d;
      valid_q         <= valid_d;
      resp_valid_q    <= resp_valid_d;
      resp_addr_q     <= resp_addr_d;
      resp_data_q     <= resp_data_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_req_addr_q  <= mem_req_addr_d;
      if (accept) addr_q <= req_addr_i;
    end
  end

  // Array storage carries no reset; only the valid bits gate its use.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (fill_we) begin
        tag_mem[addr_idx]  <= addr_tag;
        data_mem[addr_idx] <= mem_resp_data_i;
      end
      if (accept) begin
        rd_tag_q  <= tag_mem[req_idx];
        rd_data_q <= data_mem[req_idx];
      end
    end
  end

endmodule
